// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared state encoding and constant AR fields for the read arbiter
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_AR_SEND = 2'd1,
    ST_R_DATA  = 2'd2
  } state_e;

  localparam logic [1:0] ARLOCK       = 2'b00;
  localparam logic [3:0] ARCACHE      = 4'b0000;
  localparam logic [2:0] ARPROT       = 3'b000;
  localparam logic [3:0] DEF_M0_ID    = 4'd0;
  localparam logic [3:0] DEF_M1_ID    = 4'd1;
  localparam logic [3:0] BEAT_CNT_MAX = 4'hf;

endpackage

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - merges icache (M0) and dcache (M1) AXI3 read channels, one burst in flight
// Round-robin on ties; R channel is a combinational pass-through to the granted master.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter logic [3:0] M0_ID  = DEF_M0_ID,
  parameter logic [3:0] M1_ID  = DEF_M1_ID,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              err
);

  state_e              state_q, state_d;
  logic                grant_q, grant_d;    // 1 = M1 owns the current burst
  logic                rr_ptr_q, rr_ptr_d;
  logic [3:0]          beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;
  logic [3:0]          arid_q, arid_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [3:0]          arlen_q, arlen_d;
  logic [2:0]          arsize_q, arsize_d;
  logic [1:0]          arburst_q, arburst_d;
  logic                arvalid_q, arvalid_d;
  logic                win;
  logic                r_active;

  always_comb begin
    if (m0_arvalid && m1_arvalid) win = rr_ptr_q;
    else                          win = m1_arvalid;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    arburst_d  = arburst_q;
    arvalid_d  = arvalid_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          m0_arready = ~win;
          m1_arready = win;
          if (m0_arvalid && m1_arvalid) rr_ptr_d = ~win;
          grant_d    = win;
          arid_d     = win ? M1_ID      : M0_ID;
          araddr_d   = win ? m1_araddr  : m0_araddr;
          arlen_d    = win ? m1_arlen   : m0_arlen;
          arsize_d   = win ? m1_arsize  : m0_arsize;
          arburst_d  = win ? m1_arburst : m0_arburst;
          arvalid_d  = 1'b1;
          beat_cnt_d = 4'd0;
          state_d    = ST_AR_SEND;
        end
      end
      ST_AR_SEND: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_R_DATA;
        end
      end
      ST_R_DATA: begin
        if (rvalid && rready) begin
          if (beat_cnt_q != BEAT_CNT_MAX) beat_cnt_d = beat_cnt_q + 4'd1;
          // Faults only flag err; the data still goes to the master.
          if (rid != arid_q)                      err_d = 1'b1;
          if (rlast && (beat_cnt_q != arlen_q))   err_d = 1'b1;
          if (!rlast && (beat_cnt_q == arlen_q))  err_d = 1'b1;
          if (rlast) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    r_active  = (state_q == ST_R_DATA);
    rready    = r_active && (grant_q ? m1_rready : m0_rready);
    m0_rvalid = r_active && !grant_q && rvalid;
    m0_rdata  = (r_active && !grant_q) ? rdata : '0;
    m0_rresp  = (r_active && !grant_q) ? rresp : 2'b00;
    m0_rlast  = r_active && !grant_q && rlast;
    m1_rvalid = r_active && grant_q && rvalid;
    m1_rdata  = (r_active && grant_q) ? rdata : '0;
    m1_rresp  = (r_active && grant_q) ? rresp : 2'b00;
    m1_rlast  = r_active && grant_q && rlast;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      rr_ptr_q   <= 1'b1;
      beat_cnt_q <= 4'd0;
      err_q      <= 1'b0;
      arid_q     <= 4'd0;
      araddr_q   <= '0;
      arlen_q    <= 4'd0;
      arsize_q   <= 3'd0;
      arburst_q  <= 2'd0;
      arvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      arid_q     <= arid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      arburst_q  <= arburst_d;
      arvalid_q  <= arvalid_d;
    end
  end

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = arburst_q;
  assign arvalid = arvalid_q;
  assign arlock  = ARLOCK;
  assign arcache = ARCACHE;
  assign arprot  = ARPROT;
  assign err     = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed bench for axi_rd_arbiter with a transaction-level reference model
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] m0_araddr = '0, m1_araddr = '0;
  logic [3:0]  m0_arlen = '0, m1_arlen = '0;
  logic [2:0]  m0_arsize = '0, m1_arsize = '0;
  logic [1:0]  m0_arburst = '0, m1_arburst = '0;
  logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
  logic        m0_rready = 1'b1, m1_rready = 1'b1;
  logic        m0_arready, m1_arready, m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, araddr, rdata = '0;
  logic [1:0]  m0_rresp, m1_rresp, arburst, arlock, rresp = '0;
  logic [3:0]  arid, arlen, arcache, rid = '0;
  logic [2:0]  arsize, arprot;
  logic        arvalid, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready, err;

  axi_rd_arbiter dut (
    .aclk(aclk), .areset(areset),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err(err)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_miss = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: burst-level view (phase 0 free, 1 address pending, 2 data)
  int          cyc = 0;
  int          mp_phase = 0, mp_owner = 0, mp_ptr = 1, mp_beats = 0;
  bit          mp_err = 0;
  logic [3:0]  mp_id = '0, mp_len = '0;
  logic [31:0] mp_addr = '0;
  logic [2:0]  mp_size = '0;
  logic [1:0]  mp_burst = '0;

  initial begin
    forever begin
      @(posedge aclk or posedge areset);
      if (areset) begin
        mp_phase = 0; mp_owner = 0; mp_ptr = 1; mp_beats = 0; mp_err = 0;
        mp_id = '0; mp_len = '0; mp_addr = '0; mp_size = '0; mp_burst = '0;
      end else begin
        cyc++;
        case (mp_phase)
          0: if (m0_arvalid || m1_arvalid) begin
            int w;
            w = (m0_arvalid && m1_arvalid) ? mp_ptr : (m1_arvalid ? 1 : 0);
            if (m0_arvalid && m1_arvalid) mp_ptr = 1 - w;
            mp_owner = w;
            mp_id    = (w == 1) ? 4'd1 : 4'd0;
            mp_addr  = (w == 1) ? m1_araddr : m0_araddr;
            mp_len   = (w == 1) ? m1_arlen : m0_arlen;
            mp_size  = (w == 1) ? m1_arsize : m0_arsize;
            mp_burst = (w == 1) ? m1_arburst : m0_arburst;
            mp_beats = 0;
            mp_phase = 1;
          end
          1: if (arready) mp_phase = 2;
          2: if (rvalid && ((mp_owner == 1) ? m1_rready : m0_rready)) begin
            if (rid != mp_id) mp_err = 1;
            if (rlast != (mp_beats == int'(mp_len))) mp_err = 1;
            if (mp_beats < 15) mp_beats++;
            if (rlast) mp_phase = 0;
          end
          default: mp_phase = 0;
        endcase
      end
    end
  end

  function automatic void compare_cycle();
    int w;
    bit acc, d0, d1;
    w   = (m0_arvalid && m1_arvalid) ? mp_ptr : (m1_arvalid ? 1 : 0);
    acc = (mp_phase == 0) && (m0_arvalid || m1_arvalid) && !areset;
    d0  = (mp_phase == 2) && (mp_owner == 0);
    d1  = (mp_phase == 2) && (mp_owner == 1);
    chk("m0_arready", 64'(m0_arready), 64'(acc && w == 0));
    chk("m1_arready", 64'(m1_arready), 64'(acc && w == 1));
    chk("arvalid", 64'(arvalid), 64'(mp_phase == 1));
    chk("arid", 64'(arid), 64'(mp_id));
    chk("araddr", 64'(araddr), 64'(mp_addr));
    chk("arlen", 64'(arlen), 64'(mp_len));
    chk("arsize", 64'(arsize), 64'(mp_size));
    chk("arburst", 64'(arburst), 64'(mp_burst));
    chk("ar_consts", 64'({arlock, arcache, arprot}), 64'd0);
    chk("rready", 64'(rready), 64'(d0 ? m0_rready : (d1 ? m1_rready : 1'b0)));
    chk("m0_rvalid", 64'(m0_rvalid), 64'(d0 && rvalid));
    chk("m0_rdata", 64'(m0_rdata), 64'(d0 ? rdata : 32'd0));
    chk("m0_rresp", 64'(m0_rresp), 64'(d0 ? rresp : 2'd0));
    chk("m0_rlast", 64'(m0_rlast), 64'(d0 && rlast));
    chk("m1_rvalid", 64'(m1_rvalid), 64'(d1 && rvalid));
    chk("m1_rdata", 64'(m1_rdata), 64'(d1 ? rdata : 32'd0));
    chk("m1_rresp", 64'(m1_rresp), 64'(d1 ? rresp : 2'd0));
    chk("m1_rlast", 64'(m1_rlast), 64'(d1 && rlast));
    chk("err", 64'(err), 64'(mp_err));
  endfunction

  // Event logs built from observed DUT activity, checked against literals by the tests
  int          grants[$], grant_cyc[$], last_cyc[$];
  logic [31:0] got0[$], got1[$];

  initial begin
    forever begin
      @(negedge aclk);
      compare_cycle();
      if (m0_arready) begin grants.push_back(0); grant_cyc.push_back(cyc); end
      if (m1_arready) begin grants.push_back(1); grant_cyc.push_back(cyc); end
      if (m0_rvalid && m0_rready) got0.push_back(m0_rdata);
      if (m1_rvalid && m1_rready) got1.push_back(m1_rdata);
      if (rvalid && rready && rlast) last_cyc.push_back(cyc);
    end
  end

  // Masters: each keeps arvalid high while it has bursts pending
  int          pend0 = 0, pend1 = 0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [3:0]  len0 = '0, len1 = '0;
  logic        acc0, acc1;

  initial begin
    forever begin
      @(negedge aclk);
      acc0 = m0_arvalid && m0_arready;
      acc1 = m1_arvalid && m1_arready;
      @(posedge aclk);
      #2;
      if (areset) begin
        pend0 = 0; pend1 = 0;
      end else begin
        if (acc0) begin pend0--; addr0 += 32'h40; end
        if (acc1) begin pend1--; addr1 += 32'h40; end
      end
      m0_arvalid = (pend0 > 0); m0_araddr = addr0; m0_arlen = len0; m0_arsize = 3'd2; m0_arburst = 2'd1;
      m1_arvalid = (pend1 > 0); m1_araddr = addr1; m1_arlen = len1; m1_arsize = 3'd3; m1_arburst = 2'd2;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = '0; rdata = '0; rresp = '0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    grants.delete(); grant_cyc.delete(); last_cyc.delete(); got0.delete(); got1.delete();
    tick();
  endtask

  logic [3:0]  ar_seen_id, ar_seen_len;
  logic [31:0] ar_seen_addr, ar_hold_addr;
  int          ar_seen_cyc;

  task automatic slave_burst(input int ar_delay, input logic [3:0] rid_v, input int nbeats,
                             input int stall_at, input int stall_len, input logic [31:0] base,
                             input bit give_last);
    int guard;
    guard = 0;
    while (!arvalid && guard < 30) begin tick(); guard++; end
    if (!arvalid) begin
      chk("ar_wait_timeout", 64'd0, 64'd1);
      return;
    end
    ar_seen_id = arid; ar_seen_addr = araddr; ar_seen_len = arlen; ar_seen_cyc = cyc;
    repeat (ar_delay) tick();
    ar_hold_addr = araddr;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      rvalid = 1'b1; rdata = base + 32'(i); rresp = 2'(i); rid = rid_v;
      rlast = give_last && (i == nbeats - 1);
      if (i == stall_at) begin
        m0_rready = 1'b0; m1_rready = 1'b0;
        repeat (stall_len) tick();
        m0_rready = 1'b1; m1_rready = 1'b1;
      end
      guard = 0;
      #1;
      while (!rready && guard < 20) begin tick(); #1; guard++; end
      if (!rready) begin
        chk("r_wait_timeout", 64'd0, 64'd1);
        break;
      end
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  function automatic int grant_seq();
    int s = 0;
    foreach (grants[i]) s = s * 10 + grants[i] + 1;
    return s;
  endfunction

  function automatic int q_at(int q[$], int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  initial begin
    // 1: M0 alone, 8-beat burst
    do_reset();
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    addr0 = 32'hBFC0_0000; len0 = 4'd7; pend0 = 1;
    slave_burst(0, 4'd0, 8, -1, 0, 32'h1000, 1'b1);
    chk("t1_grant_seq", 64'(grant_seq()), 64'd1);
    chk("t1_ar_latency", 64'(ar_seen_cyc - q_at(grant_cyc, 0)), 64'd1);
    chk("t1_arid", 64'(ar_seen_id), 64'd0);
    chk("t1_araddr", 64'(ar_seen_addr), 64'hBFC0_0000);
    chk("t1_arlen", 64'(ar_seen_len), 64'd7);
    chk("t1_m0_beats", 64'(got0.size()), 64'd8);
    foreach (got0[i]) chk("t1_m0_data", 64'(got0[i]), 64'(32'h1000 + 32'(i)));
    chk("t1_m1_beats", 64'(got1.size()), 64'd0);

    // 2: simultaneous requests after reset, M1 first
    do_reset();
    addr0 = 32'h0000_2000; len0 = 4'd3; addr1 = 32'h0000_3000; len1 = 4'd3;
    pend0 = 1; pend1 = 1;
    slave_burst(0, 4'd1, 4, -1, 0, 32'h2000, 1'b1);
    slave_burst(0, 4'd0, 4, -1, 0, 32'h2100, 1'b1);
    chk("t2_grant_seq", 64'(grant_seq()), 64'd21);
    chk("t2_regrant_gap", 64'(q_at(grant_cyc, 1) - q_at(last_cyc, 0)), 64'd1);
    chk("t2_m1_first", 64'(got1.size() > 0 ? got1[0] : 32'hDEAD), 64'h2000);
    chk("t2_m0_first", 64'(got0.size() > 0 ? got0[0] : 32'hDEAD), 64'h2100);

    // 3: continuous requests from both
    do_reset();
    addr0 = 32'h0000_4000; len0 = 4'd1; addr1 = 32'h0000_6000; len1 = 4'd2;
    pend0 = 2; pend1 = 2;
    slave_burst(0, 4'd1, 3, -1, 0, 32'h3000, 1'b1);
    slave_burst(0, 4'd0, 2, -1, 0, 32'h3100, 1'b1);
    slave_burst(0, 4'd1, 3, -1, 0, 32'h3200, 1'b1);
    slave_burst(0, 4'd0, 2, -1, 0, 32'h3300, 1'b1);
    chk("t3_grant_seq", 64'(grant_seq()), 64'd2121);
    chk("t3_err", 64'(err), 64'd0);

    // 4: slave stalls AR for 5 cycles
    do_reset();
    addr0 = 32'h8000_0000; len0 = 4'd1; pend0 = 1;
    slave_burst(5, 4'd0, 2, -1, 0, 32'h4000, 1'b1);
    chk("t4_hold_addr", 64'(ar_hold_addr), 64'h8000_0000);
    chk("t4_grant_count", 64'(grants.size()), 64'd1);

    // 5: master back-pressure mid-burst
    do_reset();
    addr1 = 32'h0000_9000; len1 = 4'd5; pend1 = 1;
    slave_burst(0, 4'd1, 6, 2, 3, 32'h5000, 1'b1);
    chk("t5_m1_beats", 64'(got1.size()), 64'd6);
    foreach (got1[i]) chk("t5_m1_order", 64'(got1[i]), 64'(32'h5000 + 32'(i)));
    chk("t5_m0_beats", 64'(got0.size()), 64'd0);

    // 6a: wrong rid
    do_reset();
    addr1 = 32'h0000_A000; len1 = 4'd1; pend1 = 1;
    slave_burst(0, 4'd3, 2, -1, 0, 32'h6000, 1'b1);
    chk("t6a_err", 64'(err), 64'd1);
    chk("t6a_data_forwarded", 64'(got1.size()), 64'd2);

    // 6b: early rlast, then a new grant proves the return to idle
    do_reset();
    addr0 = 32'h0000_B000; len0 = 4'd7; pend0 = 1;
    slave_burst(0, 4'd0, 4, -1, 0, 32'h7000, 1'b1);
    chk("t6b_err", 64'(err), 64'd1);
    addr1 = 32'h0000_C000; len1 = 4'd0; pend1 = 1;
    slave_burst(0, 4'd1, 1, -1, 0, 32'h7100, 1'b1);
    chk("t6b_grant_seq", 64'(grant_seq()), 64'd12);
    chk("t6b_err_sticky", 64'(err), 64'd1);

    // 6d: final beat index reached without rlast
    do_reset();
    addr0 = 32'h0000_D000; len0 = 4'd1; pend0 = 1;
    slave_burst(0, 4'd0, 3, -1, 0, 32'h7200, 1'b1);
    chk("t6d_err", 64'(err), 64'd1);

    // 6c: reset in the middle of a faulty burst
    do_reset();
    addr0 = 32'h0000_E000; len0 = 4'd7; pend0 = 1;
    slave_burst(0, 4'd3, 3, -1, 0, 32'h7300, 1'b0);
    chk("t6c_err_before", 64'(err), 64'd1);
    rvalid = 1'b1; rdata = 32'h7303; rid = 4'd0;
    areset = 1'b1;
    @(negedge aclk);
    #1;
    chk("t6c_err", 64'(err), 64'd0);
    chk("t6c_arvalid", 64'(arvalid), 64'd0);
    chk("t6c_araddr", 64'(araddr), 64'd0);
    chk("t6c_rready", 64'(rready), 64'd0);
    chk("t6c_m0_rvalid", 64'(m0_rvalid), 64'd0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    n_miss++;
    $display("FAIL watchdog: got timeout, expected test sequence completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
